// File: rtl/ring_buf_param.sv
// ring_buf_param: parametrised FIFO ring buffer with counter-based occupancy and request/done pulse handshake
//   Optional feature macro: RING_BUF_ERR_FLAG_EN (adds sticky overflow/underflow outputs)
//   clk          in   clock, all state on posedge
//   rst          in   asynchronous active-high reset
//   flush        in   synchronous clear, priority over push/pop
//   i_order      in   push request (level)
//   i_data       in   push data
//   i_done       out  one-cycle pulse, previous push accepted
//   o_order      in   pop request (level)
//   o_data       out  registered pop data, held between pops
//   o_done       out  one-cycle pulse, previous pop succeeded
//   count        out  occupancy 0..DEPTH
//   empty/full   out  count==0 / count==DEPTH
//   almost_full  out  count>=ALMOST_FULL
//   overflow     out  sticky rejected-push flag (macro only)
//   underflow    out  sticky rejected-pop flag (macro only)
`ifndef LEN_RING_BUF_ADDR
`define LEN_RING_BUF_ADDR 2
`endif
module ring_buf_param #(
    parameter int LEN_DATA    = 8,
    parameter int LEN_ADDR    = `LEN_RING_BUF_ADDR,
    parameter int ALMOST_FULL = 2**LEN_ADDR - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                i_order,
    input  logic [LEN_DATA-1:0] i_data,
    output logic                i_done,
    input  logic                o_order,
    output logic [LEN_DATA-1:0] o_data,
    output logic                o_done,
    output logic [LEN_ADDR:0]   count,
    output logic                empty,
    output logic                full,
`ifdef RING_BUF_ERR_FLAG_EN
    output logic                overflow,
    output logic                underflow,
`endif
    output logic                almost_full
);
    localparam int DEPTH = 2**LEN_ADDR;
    localparam logic [LEN_ADDR:0] DEPTH_C = (LEN_ADDR+1)'(DEPTH);
    localparam logic [LEN_ADDR:0] AF_C    = (LEN_ADDR+1)'(ALMOST_FULL);
    logic [LEN_DATA-1:0] d [DEPTH];
    logic [LEN_ADDR-1:0] i_addr, o_addr;
    logic                push_ok, pop_ok;
    assign empty       = count == '0;
    assign full        = count == DEPTH_C;
    assign almost_full = count >= AF_C;
    // A simultaneous pop frees the slot a full-buffer push needs; a simultaneous
    // push supplies the data an empty-buffer pop needs (bypass).
    assign push_ok = i_order & (~full | o_order);
    assign pop_ok  = o_order & (~empty | i_order);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_addr <= '0;
            o_addr <= '0;
            count  <= '0;
            o_data <= '0;
            i_done <= 1'b0;
            o_done <= 1'b0;
        end else if (flush) begin
            i_addr <= '0;
            o_addr <= '0;
            count  <= '0;
            i_done <= 1'b0;
            o_done <= 1'b0;
        end else begin
            i_done <= push_ok;
            o_done <= pop_ok;
            if (push_ok) i_addr <= i_addr + 1'b1;
            if (pop_ok) begin
                o_addr <= o_addr + 1'b1;
                o_data <= empty ? i_data : d[o_addr];
            end
            count <= count + (LEN_ADDR+1)'(push_ok) - (LEN_ADDR+1)'(pop_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (!flush && push_ok) d[i_addr] <= i_data;
    end
`ifdef RING_BUF_ERR_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (i_order & ~push_ok);
            underflow <= underflow | (o_order & ~pop_ok);
        end
    end
`endif
endmodule

// File: tb/tb_ring_buf_param.sv
// tb_ring_buf_param: scoreboard-based self-checking bench for ring_buf_param (LEN_DATA=8, LEN_ADDR=2)
module tb_ring_buf_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       i_order = 1'b0;
    logic [7:0] i_data = '0;
    logic       i_done;
    logic       o_order = 1'b0;
    logic [7:0] o_data;
    logic       o_done;
    logic [2:0] count;
    logic       empty, full, almost_full;
`ifdef RING_BUF_ERR_FLAG_EN
    logic       overflow, underflow;
`endif
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    ring_buf_param #(.LEN_DATA(8), .LEN_ADDR(2), .ALMOST_FULL(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .i_order(i_order), .i_data(i_data), .i_done(i_done),
        .o_order(o_order), .o_data(o_data), .o_done(o_done),
        .count(count), .empty(empty), .full(full),
`ifdef RING_BUF_ERR_FLAG_EN
        .overflow(overflow), .underflow(underflow),
`endif
        .almost_full(almost_full)
    );

    // Drive one cycle of requests from a negedge; outputs of that posedge are
    // stable at the following negedge, where the caller checks them.
    task automatic step(input logic po, input logic pp, input logic [7:0] dv, input logic fl);
        i_order = po;
        o_order = pp;
        i_data  = dv;
        flush   = fl;
        @(negedge clk);
        i_order = 1'b0;
        o_order = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got e%b f%b af%b want e1 f0 af0", empty, full, almost_full); end
        n_checks++; if (o_data !== 8'h00 || i_done !== 1'b0 || o_done !== 1'b0) begin n_fail++; $display("FAIL reset_out got d%h id%b od%b want d00 id0 od0", o_data, i_done, o_done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, vals[i], 1'b0);
            sb.push_back(vals[i]);
            n_checks++; if (i_done !== 1'b1) begin n_fail++; $display("FAIL fill_idone[%0d] got %b want 1", i, i_done); end
            n_checks++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
            n_checks++; if (almost_full !== (i >= 2) || full !== (i == 3)) begin n_fail++; $display("FAIL fill_flags[%0d] got af%b f%b want af%b f%b", i, almost_full, full, i >= 2, i == 3); end
        end
        step(1'b1, 1'b0, 8'h55, 1'b0);
        n_checks++; if (i_done !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL fill_overpush got id%b cnt%0d want id0 cnt4", i_done, count); end
`ifdef RING_BUF_ERR_FLAG_EN
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow got %b want 1", overflow); end
`endif
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            exp_d = sb.pop_front();
            n_checks++; if (o_done !== 1'b1 || o_data !== exp_d) begin n_fail++; $display("FAIL drain[%0d] got od%b d%h want od1 d%h", i, o_done, o_data, exp_d); end
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (o_done !== 1'b0 || o_data !== 8'h44 || empty !== 1'b1) begin n_fail++; $display("FAIL drain_underpop got od%b d%h e%b want od0 d44 e1", o_done, o_data, empty); end
`ifdef RING_BUF_ERR_FLAG_EN
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow got %b want 1", underflow); end
`endif
    endtask

    task automatic test_bypass();
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        n_checks++; if (o_data !== 8'hA5 || i_done !== 1'b1 || o_done !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL bypass got d%h id%b od%b cnt%0d want dA5 id1 od1 cnt0", o_data, i_done, o_done, count); end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++; if (i_done !== 1'b0 || o_done !== 1'b0) begin n_fail++; $display("FAIL pulse_width got id%b od%b want id0 od0", i_done, o_done); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, vals[i], 1'b0);
            sb.push_back(vals[i]);
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fpp_full got %b want 1", full); end
        step(1'b1, 1'b1, 8'h99, 1'b0);
        sb.push_back(8'h99);
        exp_d = sb.pop_front();
        n_checks++; if (o_data !== exp_d || count !== 3'd4 || i_done !== 1'b1 || o_done !== 1'b1) begin n_fail++; $display("FAIL fpp_both got d%h cnt%0d id%b od%b want d%h cnt4 id1 od1", o_data, count, i_done, o_done, exp_d); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            exp_d = sb.pop_front();
            n_checks++; if (o_done !== 1'b1 || o_data !== exp_d) begin n_fail++; $display("FAIL fpp_wrap[%0d] got od%b d%h want od1 d%h", i, o_done, o_data, exp_d); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty got %b want 1", empty); end
    endtask

    task automatic test_flush();
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h61, 1'b0);
        step(1'b1, 1'b0, 8'h62, 1'b0);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL flush_pre got %0d want 2", count); end
        step(1'b1, 1'b1, 8'h63, 1'b1);
        n_checks++; if (count !== 3'd0 || i_done !== 1'b0 || o_done !== 1'b0 || o_data !== 8'h99) begin n_fail++; $display("FAIL flush got cnt%0d id%b od%b d%h want cnt0 id0 od0 d99", count, i_done, o_done, o_data); end
`ifdef RING_BUF_ERR_FLAG_EN
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL flush_flags got ov%b un%b want 0 0", overflow, underflow); end
`endif
        sb.delete();
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 8'h71, 1'b0);
        step(1'b1, 1'b0, 8'h72, 1'b0);
        step(1'b1, 1'b0, 8'h73, 1'b0);
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL arst_pre got %0d want 3", count); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0 || o_data !== 8'h00 || empty !== 1'b1) begin n_fail++; $display("FAIL arst got cnt%0d d%h e%b want cnt0 d00 e1", count, o_data, empty); end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        sb.push_back(8'h5A);
        n_checks++; if (i_done !== 1'b1 || count !== 3'd1) begin n_fail++; $display("FAIL arst_push got id%b cnt%0d want id1 cnt1", i_done, count); end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        exp_d = sb.pop_front();
        n_checks++; if (o_done !== 1'b1 || o_data !== exp_d || count !== 3'd0) begin n_fail++; $display("FAIL arst_pop got od%b d%h cnt%0d want od1 d%h cnt0", o_done, o_data, count, exp_d); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_bypass();
        test_full_pushpop();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ring_buf_param.md
Name: ring_buf_param

Overview:
- Parametrised successor to the byte ring buffer.
- Configurable data width and depth.
- Uses all 2**LEN_ADDR slots, because occupancy is tracked with an explicit counter rather than a sacrificed slot.
- Adds occupancy count, full/empty and almost-full flags, a synchronous flush, and full-buffer simultaneous push/pop.
- Sits between UART rx/tx and the core I/O path, and anywhere else a small decoupling FIFO with request/done pulse handshake is needed.

Parameters:
- LEN_DATA, 8, data width in bits.
- LEN_ADDR, `LEN_RING_BUF_ADDR, address width; DEPTH = 2**LEN_ADDR entries.
- ALMOST_FULL, 2**LEN_ADDR-1, count threshold at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear of buffer contents.
- i_order  in  1  push request (level, sampled every cycle).
- i_data  in  LEN_DATA  push data.
- i_done  out  1  one-cycle pulse: push sampled on previous edge was accepted.
- o_order  in  1  pop request (level, sampled every cycle).
- o_data  out  LEN_DATA  registered pop data, valid while o_done=1 and held afterwards.
- o_done  out  1  one-cycle pulse: pop sampled on previous edge succeeded.
- count  out  LEN_ADDR+1  current occupancy, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- almost_full  out  1  count>=ALMOST_FULL.

Behaviour:
- Reset: asynchronous, active-high.
  - Clears i_addr, o_addr, count, o_data, i_done and o_done to 0.
  - Afterwards empty=1, full=0, almost_full=0.
  - Storage array is not reset; its contents are don't-care.
  - Reset asserted mid-operation discards all data and any pending done pulse immediately.
- Registered state:
  - i_addr (next write slot), o_addr (next read slot), count.
  - Both pointers are LEN_ADDR bits and wrap modulo DEPTH with no special case.
- Derived flags: empty, full and almost_full are combinational from count, so they reflect the state after the last edge.
- Done pulses: i_done and o_done default to 0 every cycle and pulse for exactly one cycle per accepted operation. The latency from request edge to done is 1 cycle.
- Push only (i_order=1, o_order=0):
  - If full: ignored, i_done=0, no state change.
  - Else: d[i_addr]<=i_data, i_addr+1, count+1, i_done<=1.
- Pop only (i_order=0, o_order=1):
  - If empty: ignored, o_done=0, o_data holds.
  - Else: o_data<=d[o_addr], o_addr+1, count-1, o_done<=1.
- Simultaneous push and pop:
  - Empty: bypass. o_data<=i_data, d[i_addr]<=i_data, both pointers +1, count unchanged (0), i_done=o_done=1.
  - Full: both accepted. Pop reads the old d[o_addr] before overwrite, the write lands at i_addr (==o_addr), both pointers +1, count stays DEPTH, both dones pulse.
  - Otherwise: both accepted, count unchanged, both dones pulse.
- Flush: has priority over push and pop in the same cycle.
  - i_addr, o_addr and count go to 0.
  - No done pulses in that cycle; o_data holds.
  - Requests in the flush cycle are dropped.
- No request: state holds, dones 0.
- count arithmetic is LEN_ADDR+1 bits and never wraps; the full/empty guards make overflow and underflow impossible.

Optional Feature:
- Macro: RING_BUF_ERR_FLAG_EN.
- When defined, two extra outputs are compiled in:
  - overflow: 1 bit, sticky; set on the edge after a push is rejected because the buffer is full.
  - underflow: 1 bit, sticky; set on the edge after a pop is rejected because the buffer is empty.
- Both flags clear only on rst or flush.
- Simultaneous push and pop at full or at empty is not an error.
- When not defined, the ports and logic are absent and rejected requests are silently dropped.

Test Plan:
- LEN_DATA=8, LEN_ADDR=2: after rst, push 0x11,0x22,0x33,0x44 on consecutive cycles -> i_done pulses 4 times, count=4, full=1, almost_full=1 from count=3. A fifth push of 0x55 -> i_done=0, count stays 4, overflow=1 if enabled.
- From full, pop 4 times -> o_data sequence 0x11,0x22,0x33,0x44, each with an o_done pulse. A fifth pop -> o_done=0, o_data holds 0x44, empty=1, underflow=1 if enabled.
- Empty buffer, i_order=o_order=1 with i_data=0xA5 -> next cycle o_data=0xA5, i_done=o_done=1, count=0.
- Full buffer holding 0x11..0x44, simultaneous push 0x99 and pop -> o_data=0x11, count=4. Subsequent pops return 0x22,0x33,0x44,0x99, exercising pointer wrap.
- Count=2, assert flush together with i_order and o_order -> count=0, no done pulses, o_data unchanged, error flags cleared.
- Assert rst asynchronously between edges while count=3 -> count, pointers and o_data read 0 immediately. After release, a push and pop of 0x5A works normally.
